trap_sequencer: RTL
===================

# trap_sequencer

Sequences every machine-mode control transfer for the CSR unit: timer interrupt entry, `ecall`/`ebreak` trap entry and `mret` return.
It watches the retiring instruction at write-back and the CLINT timer line. It kills the triggering instruction, holds the pipeline front and waits for the in-flight AXI transaction to drain. It then issues a single-cycle commit command to the CSR file (mepc/mcause/mstatus update) and hands the new PC to fetch through a valid/ready handshake.

## Interface
Parameters:
- `ADDR_W`, default 64: instruction address width.
- `DATA_W`, default 64: CSR data width.
- `DRAIN_MAX`, default 256: maximum DRAIN cycles before a forced commit; must be ≥2.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inst_valid`  in  1  write-back instruction valid this cycle.
- `inst_addr`  in  ADDR_W  PC of the write-back instruction.
- `inst_ecall`  in  1  write-back instruction is `ecall`.
- `inst_ebreak`  in  1  write-back instruction is `ebreak`.
- `inst_mret`  in  1  write-back instruction is `mret`.
- `clint_mtip`  in  1  timer interrupt pending level.
- `mstatus_mie`  in  1  mstatus.MIE from the CSR file.
- `mie_mtie`  in  1  mie.MTIE (bit 7) from the CSR file.
- `mtvec`  in  ADDR_W  mtvec from the CSR file.
- `mepc`  in  ADDR_W  mepc from the CSR file.
- `bus_busy`  in  1  an AXI transaction is outstanding.
- `redirect_ready`  in  1  fetch accepts `redirect_pc`.
- `kill_wb`  out  1  suppress commit of the write-back instruction; combinational.
- `flush`  out  1  kill all younger in-flight instructions; combinational.
- `stall`  out  1  hold fetch/decode; registered state decode.
- `trap_we`  out  1  one-cycle pulse: CSR file writes `trap_mepc`/`trap_mcause` and stacks MIE into MPIE, clearing MIE.
- `mret_we`  out  1  one-cycle pulse: CSR file restores MIE from MPIE and sets MPIE.
- `trap_mepc`  out  ADDR_W  captured exception PC.
- `trap_mcause`  out  DATA_W  captured cause.
- `redirect_valid`  out  1  new PC is valid.
- `redirect_pc`  out  ADDR_W  new fetch PC.
- `drain_timeout`  out  1  sticky flag; set on a forced commit, cleared only by `rst`.

## Operation
- `irq = clint_mtip & mstatus_mie & mie_mtie`.
- `accept = (state==IDLE) & inst_valid & (irq | inst_ecall | inst_ebreak | inst_mret)`.

Priority when several events coincide: `irq` > `ecall` > `ebreak` > `mret`. Only the winner is captured.

On `accept`, the block captures:
- `kind` (TRAP/RET).
- `trap_mepc <= inst_addr` for every kind.
- `trap_mcause`:
  - irq: `{1'b1, (DATA_W-4)'b0, 3'd7}` = 0x8000_0000_0000_0007.
  - ecall: 11.
  - ebreak: 3.
  - mret: unchanged.

States:
- **IDLE**: `stall`=0. `kill_wb`=`flush`=`accept`. On `accept` → DRAIN, `drain_cnt` cleared.
- **DRAIN**: `stall`=1.
  - `!bus_busy` → COMMIT.
  - else `drain_cnt`++; if `drain_cnt == DRAIN_MAX-1` → COMMIT and set `drain_timeout`.
- **COMMIT**: `stall`=1. `trap_we`=1 if TRAP, `mret_we`=1 if RET.
  - `redirect_pc` is registered: `{mtvec[ADDR_W-1:2],2'b00}` for TRAP, `mepc` sampled this cycle for RET.
  - → REDIRECT.
- **REDIRECT**: `stall`=1, `redirect_valid`=1, `redirect_pc` held stable. On `redirect_ready` → IDLE.

Further rules:
- `inst_valid` and all event inputs are ignored outside IDLE. Changes of `clint_mtip`, `mstatus_mie` or `mie_mtie` after `accept` do not alter the captured trap.
- `mret` with `irq` pending in the same cycle takes the interrupt; mepc = PC of the `mret`.
- An interrupt pending on the cycle the block returns to IDLE is accepted on the first IDLE cycle with `inst_valid`.

## Timing
- Reset (async, immediate): state=IDLE. The following are all 0: `drain_cnt`, `kind`, `trap_mepc`, `trap_mcause`, `redirect_pc`, `drain_timeout`, `stall`, `trap_we`, `mret_we`, `redirect_valid`, `kill_wb`, `flush`.
- Reset during any state aborts the sequence; no `trap_we`/`mret_we` is issued afterward.
- Minimum sequence: accept at T; DRAIN T+1; COMMIT T+2 (`trap_we`/`mret_we`); REDIRECT T+3 (`redirect_valid`); IDLE T+4 if `redirect_ready` at T+3.
- Each DRAIN cycle with `bus_busy`=1 adds one cycle. DRAIN lasts at most `DRAIN_MAX` cycles.
- `redirect_valid` holds with a constant `redirect_pc` until the `redirect_ready` cycle. It drops the cycle after.
- `trap_we` and `mret_we` are exactly one cycle each and mutually exclusive.
- `trap_mepc`/`trap_mcause` remain stable from T+1 until the next `accept`.
- `drain_cnt` is `$clog2(DRAIN_MAX)` bits and never wraps.

## Test plan
- Ecall at 0x8000_0100, `mtvec`=0x8000_0523, `bus_busy`=0, `redirect_ready`=1: `kill_wb`/`flush` at T; `trap_we` at T+2 with mepc=0x8000_0100, mcause=11; `redirect_valid` at T+3 with `redirect_pc`=0x8000_0520; IDLE at T+4.
- Timer interrupt with `mstatus_mie`=`mie_mtie`=1 and `clint_mtip`=1, coincident with `ebreak` at 0x8000_0200: mcause=0x8000_0000_0000_0007, mepc=0x8000_0200. Repeat with `mstatus_mie`=0: an ebreak trap with mcause=3.
- `mret` with `mepc`=0x8000_0404, `bus_busy` high for 5 DRAIN cycles: `mret_we` at T+7; `redirect_pc`=0x8000_0404; `trap_we` never asserted.
- `bus_busy` stuck at 1, `DRAIN_MAX`=8: COMMIT after 8 DRAIN cycles; `drain_timeout` rises and stays 1 through later traps until `rst`.
- `redirect_ready` held low 4 cycles: `redirect_valid`/`redirect_pc` stable for 5 cycles; an ecall presented meanwhile is ignored.
- `rst` asserted mid-DRAIN and mid-REDIRECT: all outputs 0 asynchronously; no `trap_we` afterward; a new ecall after release is accepted normally.

Source files
------------

// File: rtl/trap_sequencer_if.sv
// Fetch redirect handshake between the trap sequencer and the fetch stage.
// The sequencer owns valid/pc; fetch owns ready.
interface trap_sequencer_if #(
    parameter int ADDR_W = 64
);
    logic              redirect_valid;
    logic              redirect_ready;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready
    );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode control-transfer sequencer: timer interrupt, ecall/ebreak entry and mret return.
// Kills the write-back instruction, drains the bus, commits CSR updates and redirects fetch.
module trap_sequencer #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int DRAIN_MAX = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_valid,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_ecall,
    input  logic              inst_ebreak,
    input  logic              inst_mret,
    input  logic              clint_mtip,
    input  logic              mstatus_mie,
    input  logic              mie_mtie,
    input  logic [ADDR_W-1:0] mtvec,
    input  logic [ADDR_W-1:0] mepc,
    input  logic              bus_busy,
    trap_sequencer_if.master  redir,
    output logic              kill_wb,
    output logic              flush,
    output logic              stall,
    output logic              trap_we,
    output logic              mret_we,
    output logic [ADDR_W-1:0] trap_mepc,
    output logic [DATA_W-1:0] trap_mcause,
    output logic              drain_timeout
);

    localparam int CNT_W = $clog2(DRAIN_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_MAX - 1);

    localparam logic [DATA_W-1:0] CAUSE_TIMER  = {1'b1, {(DATA_W-4){1'b0}}, 3'd7};
    localparam logic [DATA_W-1:0] CAUSE_ECALL  = DATA_W'(11);
    localparam logic [DATA_W-1:0] CAUSE_EBREAK = DATA_W'(3);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        COMMIT,
        REDIRECT
    } state_e;

    typedef enum logic {
        KIND_TRAP = 1'b0,
        KIND_RET  = 1'b1
    } kind_e;

    state_e            state;
    state_e            state_next;
    kind_e             kind;
    logic [CNT_W-1:0]  drain_cnt;
    logic [ADDR_W-1:0] redirect_pc_q;
    logic              irq;
    logic              accept;
    logic              drain_last;

    // Reset gates accept so kill/flush read 0 while rst is held.
    assign irq        = clint_mtip & mstatus_mie & mie_mtie;
    assign accept     = !rst && (state == IDLE) && inst_valid &&
                        (irq || inst_ecall || inst_ebreak || inst_mret);
    assign drain_last = (drain_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (accept) state_next = DRAIN;
            DRAIN:    if (!bus_busy || drain_last) state_next = COMMIT;
            COMMIT:   state_next = REDIRECT;
            REDIRECT: if (redir.redirect_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        kill_wb              = accept;
        flush                = accept;
        stall                = (state != IDLE);
        trap_we              = (state == COMMIT) && (kind == KIND_TRAP);
        mret_we              = (state == COMMIT) && (kind == KIND_RET);
        redir.redirect_valid = (state == REDIRECT);
    end

    assign redir.redirect_pc = redirect_pc_q;

    // Capture happens only on accept, so later changes to the event lines cannot alter a trap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt     <= '0;
            kind          <= KIND_TRAP;
            trap_mepc     <= '0;
            trap_mcause   <= '0;
            redirect_pc_q <= '0;
            drain_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        drain_cnt <= '0;
                        trap_mepc <= inst_addr;
                        if (irq) begin
                            kind        <= KIND_TRAP;
                            trap_mcause <= CAUSE_TIMER;
                        end else if (inst_ecall) begin
                            kind        <= KIND_TRAP;
                            trap_mcause <= CAUSE_ECALL;
                        end else if (inst_ebreak) begin
                            kind        <= KIND_TRAP;
                            trap_mcause <= CAUSE_EBREAK;
                        end else begin
                            kind        <= KIND_RET;
                        end
                    end
                end
                DRAIN: begin
                    if (bus_busy) begin
                        if (drain_last) begin
                            drain_timeout <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    // Trap vectors are 4-byte aligned regardless of the mtvec mode bits.
                    if (kind == KIND_TRAP) begin
                        redirect_pc_q <= mtvec & ~ADDR_W'(3);
                    end else begin
                        redirect_pc_q <= mepc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
